// File: rtl/mano_control_unit.sv
// Sequencer and register file for the 8-bit basic computer: fetches from the
// 16x8 MEMORY block, resolves indirect addresses and executes instructions.
module mano_control_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] AC_OUT,
    output logic       E_OUT,
    output logic [3:0] PC_OUT,
    output logic [7:0] IR_OUT,
    output logic       BUSY,
    output logic       HALTED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_AR,
        S_FETCH_IR,
        S_DECODE,
        S_INDIRECT,
        S_OPERAND,
        S_EXECUTE,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_REG = 3'b111;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] ar_q, ar_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] dr_q, dr_d;
    logic [7:0] ac_q, ac_d;
    logic       e_q, e_d;

    logic       ir_i;
    logic [2:0] ir_op;
    logic       is_mem_ref;
    logic [8:0] add_sum;
    logic [7:0] rr_ac;

    assign ir_i       = ir_q[7];
    assign ir_op      = ir_q[6:4];
    assign is_mem_ref = (ir_op == OP_AND) || (ir_op == OP_ADD) ||
                        (ir_op == OP_LDA) || (ir_op == OP_BUN);
    assign add_sum    = {1'b0, ac_q} + {1'b0, dr_q};

    // Register-reference micro-ops chain CLA -> CMA -> INC within one cycle.
    always_comb begin
        rr_ac = ac_q;
        if (ir_q[3]) rr_ac = 8'h00;
        if (ir_q[2]) rr_ac = ~rr_ac;
        if (ir_q[1]) rr_ac = rr_ac + 8'd1;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ar_d     = ar_q;
        ir_d     = ir_q;
        dr_d     = dr_q;
        ac_d     = ac_q;
        e_d      = e_q;
        mem_read = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_FETCH_AR;
            end
            S_FETCH_AR: begin
                ar_d    = pc_q;
                state_d = S_FETCH_IR;
            end
            S_FETCH_IR: begin
                mem_read = 1'b1;
                ir_d     = mem_rdata;
                pc_d     = pc_q + 4'd1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ar_d = ir_q[3:0];
                if (ir_op == OP_REG && !ir_i) begin
                    ac_d    = rr_ac;
                    state_d = ir_q[0] ? S_HALT : S_FETCH_AR;
                end else if (is_mem_ref) begin
                    if (ir_i)                 state_d = S_INDIRECT;
                    else if (ir_op == OP_BUN) state_d = S_EXECUTE;
                    else                      state_d = S_OPERAND;
                end else begin
                    state_d = S_FETCH_AR;
                end
            end
            S_INDIRECT: begin
                mem_read = 1'b1;
                ar_d     = mem_rdata[3:0];
                state_d  = (ir_op == OP_BUN) ? S_EXECUTE : S_OPERAND;
            end
            S_OPERAND: begin
                mem_read = 1'b1;
                dr_d     = mem_rdata;
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (ir_op)
                    OP_AND:  ac_d = ac_q & dr_q;
                    OP_ADD:  {e_d, ac_d} = add_sum;
                    OP_LDA:  ac_d = dr_q;
                    OP_BUN:  pc_d = ar_q;
                    default: ;
                endcase
                state_d = S_FETCH_AR;
            end
            S_HALT: begin
                if (START) state_d = S_FETCH_AR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= 4'h0;
            ar_q    <= 4'h0;
            ir_q    <= 8'h00;
            dr_q    <= 8'h00;
            ac_q    <= 8'h00;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ar_q    <= ar_d;
            ir_q    <= ir_d;
            dr_q    <= dr_d;
            ac_q    <= ac_d;
            e_q     <= e_d;
        end
    end

    // Store path is wired but unused until a store instruction exists.
    assign mem_write = 1'b0;
    assign mem_addr  = ar_q;
    assign mem_wdata = ac_q;
    assign AC_OUT    = ac_q;
    assign E_OUT     = e_q;
    assign PC_OUT    = pc_q;
    assign IR_OUT    = ir_q;
    assign BUSY      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign HALTED    = (state_q == S_HALT);

endmodule

// File: tb/tb_mano_control_unit.sv
// Bench for mano_control_unit: directed programs from the standard MEMORY image
// plus random images checked against an instruction-level reference model.
module tb_mano_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] ac_out;
    logic       e_out;
    logic [3:0] pc_out;
    logic [7:0] ir_out;
    logic       busy;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    assign mem_rdata = mem[mem_addr];

    // Instruction-level reference model state.
    logic [3:0] m_pc, m_ar;
    logic [7:0] m_ac, m_ir;
    logic       m_e, m_halted;

    mano_control_unit dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .AC_OUT    (ac_out),
        .E_OUT     (e_out),
        .PC_OUT    (pc_out),
        .IR_OUT    (ir_out),
        .BUSY      (busy),
        .HALTED    (halted)
    );

    always #5 clk = ~clk;

    task automatic load_standard;
        logic [7:0] img [16];
        img = '{8'h78, 8'h74, 8'h72, 8'h0A, 8'h1B, 8'h2C, 8'h47, 8'h8D,
                8'h9E, 8'hAF, 8'hC4, 8'hFF, 8'hFC, 8'h19, 8'h09, 8'h0B};
        for (int i = 0; i < 16; i++) mem[i] = img[i];
    endtask

    task automatic model_reset;
        m_pc = 4'h0; m_ar = 4'h0; m_ac = 8'h00; m_ir = 8'h00;
        m_e = 1'b0; m_halted = 1'b0;
    endtask

    // Called at #1 after a rising edge.
    task automatic do_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Executes one whole instruction; returns its cycle count and memory reads.
    task automatic model_step(output int cyc, output int reads);
        logic [7:0] w;
        logic [2:0] op;
        logic [3:0] ea;
        logic [8:0] s;
        w = mem[m_pc];
        m_ir = w;
        m_pc = m_pc + 4'd1;
        op = w[6:4];
        ea = w[3:0];
        if (op == 3'd7 && !w[7]) begin
            cyc = 3; reads = 1; m_ar = ea;
            if (w[3]) m_ac = 8'h00;
            if (w[2]) m_ac = ~m_ac;
            if (w[1]) m_ac = m_ac + 8'd1;
            if (w[0]) m_halted = 1'b1;
        end else if (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4) begin
            cyc   = (op == 3'd4) ? 4 : 5;
            reads = (op == 3'd4) ? 1 : 2;
            if (w[7]) begin
                ea = mem[ea][3:0];
                cyc++;
                reads++;
            end
            m_ar = ea;
            case (op)
                3'd0: m_ac = m_ac & mem[ea];
                3'd1: begin
                    s = {1'b0, m_ac} + {1'b0, mem[ea]};
                    m_e = s[8];
                    m_ac = s[7:0];
                end
                3'd2: m_ac = mem[ea];
                default: m_pc = ea;
            endcase
        end else begin
            cyc = 3; reads = 1; m_ar = ea;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        load_standard();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ac_out, e_out, pc_out, ir_out, mem_addr} !== 25'h0) begin
            errors++;
            $display("FAIL reset_regs: got ac=%h e=%b pc=%h ir=%h ar=%h, want all 0",
                     ac_out, e_out, pc_out, ir_out, mem_addr);
        end
        checks++;
        if ({mem_read, busy, halted, mem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rd=%b busy=%b halted=%b wr=%b, want 0000",
                     mem_read, busy, halted, mem_write);
        end
        rst = 1'b0;
        model_reset();
        cycles(5);
        checks++;
        if ({busy, pc_out} !== 5'h00) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%b pc=%h, want 0 0", busy, pc_out);
        end
    endtask

    task automatic test_standard_program;
        load_standard();
        do_reset();
        pulse_start();
        cycles(9);
        checks++;
        if ({ac_out, e_out, pc_out} !== {8'h00, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL reg_ref_wrap: got ac=%h e=%b pc=%h, want 00 0 3", ac_out, e_out, pc_out);
        end
        cycles(15);
        checks++;
        if ({ac_out, e_out, pc_out} !== {8'hFC, 1'b0, 4'h6}) begin
            errors++;
            $display("FAIL direct_mref: got ac=%h e=%b pc=%h, want FC 0 6", ac_out, e_out, pc_out);
        end
        cycles(4);
        checks++;
        if (pc_out !== 4'h7) begin
            errors++;
            $display("FAIL bun_direct: got pc=%h, want 7", pc_out);
        end
        cycles(12);
        checks++;
        if ({ac_out, e_out} !== {8'h5B, 1'b1}) begin
            errors++;
            $display("FAIL indirect_add_carry: got ac=%h e=%b, want 5B 1", ac_out, e_out);
        end
        cycles(6);
        checks++;
        if ({ac_out, e_out, pc_out} !== {8'hFF, 1'b1, 4'hA}) begin
            errors++;
            $display("FAIL indirect_lda: got ac=%h e=%b pc=%h, want FF 1 A", ac_out, e_out, pc_out);
        end
        cycles(5);
        checks++;
        if (pc_out !== 4'hB) begin
            errors++;
            $display("FAIL bun_indirect: got pc=%h, want B", pc_out);
        end
        cycles(6);
        checks++;
        if ({pc_out, ac_out} !== {4'hD, 8'hFF}) begin
            errors++;
            $display("FAIL nops: got pc=%h ac=%h, want D FF", pc_out, ac_out);
        end
        cycles(5);
        checks++;
        if ({ac_out, e_out} !== {8'hAE, 1'b1}) begin
            errors++;
            $display("FAIL add_direct_carry: got ac=%h e=%b, want AE 1", ac_out, e_out);
        end
    endtask

    task automatic test_reset_mid_instruction;
        load_standard();
        do_reset();
        pulse_start();
        cycles(17);
        checks++;
        if ({mem_read, busy, mem_addr} !== {1'b1, 1'b1, 4'hB}) begin
            errors++;
            $display("FAIL operand_phase: got rd=%b busy=%b ar=%h, want 1 1 B", mem_read, busy, mem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ac_out, e_out, pc_out, ir_out, mem_addr, mem_read, busy, halted} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got ac=%h e=%b pc=%h ir=%h ar=%h rd=%b busy=%b halted=%b, want all 0",
                     ac_out, e_out, pc_out, ir_out, mem_addr, mem_read, busy, halted);
        end
        rst = 1'b0;
        model_reset();
        cycles(10);
        checks++;
        if ({busy, pc_out, ac_out, mem_read} !== 14'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b pc=%h ac=%h rd=%b, want all 0", busy, pc_out, ac_out, mem_read);
        end
    endtask

    task automatic test_halt_restart;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h71;
        mem[1] = 8'h78;
        do_reset();
        pulse_start();
        cycles(3);
        checks++;
        if ({halted, busy, pc_out, ir_out} !== {1'b1, 1'b0, 4'h1, 8'h71}) begin
            errors++;
            $display("FAIL halt: got halted=%b busy=%b pc=%h ir=%h, want 1 0 1 71", halted, busy, pc_out, ir_out);
        end
        cycles(4);
        checks++;
        if ({halted, pc_out} !== {1'b1, 4'h1}) begin
            errors++;
            $display("FAIL halt_stays: got halted=%b pc=%h, want 1 1", halted, pc_out);
        end
        pulse_start();
        cycles(3);
        checks++;
        if ({halted, busy, pc_out, ac_out, ir_out} !== {1'b0, 1'b1, 4'h2, 8'h00, 8'h78}) begin
            errors++;
            $display("FAIL resume: got halted=%b busy=%b pc=%h ac=%h ir=%h, want 0 1 2 00 78",
                     halted, busy, pc_out, ac_out, ir_out);
        end
    endtask

    task automatic test_start_held;
        load_standard();
        do_reset();
        start = 1'b1;
        cycles(25);
        start = 1'b0;
        checks++;
        if ({ac_out, e_out, pc_out} !== {8'hFC, 1'b0, 4'h6}) begin
            errors++;
            $display("FAIL start_held: got ac=%h e=%b pc=%h, want FC 0 6", ac_out, e_out, pc_out);
        end
    endtask

    task automatic test_random_programs;
        int cyc, reads, nreads, nbusy;
        for (int img = 0; img < 8; img++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
            do_reset();
            pulse_start();
            for (int n = 0; n < 40; n++) begin
                model_step(cyc, reads);
                nreads = 0;
                nbusy = 0;
                for (int k = 0; k < cyc; k++) begin
                    start = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                    if (mem_read) nreads++;
                    if (busy) nbusy++;
                end
                start = 1'b0;
                checks++;
                if ({ac_out, e_out, pc_out, ir_out} !== {m_ac, m_e, m_pc, m_ir}) begin
                    errors++;
                    $display("FAIL rand_regs img%0d ins%0d: got ac=%h e=%b pc=%h ir=%h, want ac=%h e=%b pc=%h ir=%h",
                             img, n, ac_out, e_out, pc_out, ir_out, m_ac, m_e, m_pc, m_ir);
                end
                checks++;
                if (mem_addr !== m_ar) begin
                    errors++;
                    $display("FAIL rand_ar img%0d ins%0d: got %h, want %h", img, n, mem_addr, m_ar);
                end
                checks++;
                if ({halted, busy} !== {m_halted, ~m_halted}) begin
                    errors++;
                    $display("FAIL rand_status img%0d ins%0d: got halted=%b busy=%b, want halted=%b",
                             img, n, halted, busy, m_halted);
                end
                checks++;
                if (nreads != reads) begin
                    errors++;
                    $display("FAIL rand_reads img%0d ins%0d: got %0d, want %0d", img, n, nreads, reads);
                end
                checks++;
                if (nbusy != cyc - (m_halted ? 1 : 0)) begin
                    errors++;
                    $display("FAIL rand_cycles img%0d ins%0d: got busy=%0d, want %0d",
                             img, n, nbusy, cyc - (m_halted ? 1 : 0));
                end
                checks++;
                if ({mem_write, mem_wdata} !== {1'b0, m_ac}) begin
                    errors++;
                    $display("FAIL rand_wport img%0d ins%0d: got wr=%b wdata=%h, want 0 %h",
                             img, n, mem_write, mem_wdata, m_ac);
                end
                if (m_halted) begin
                    pulse_start();
                    m_halted = 1'b0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_standard_program();
        test_reset_mid_instruction();
        test_halt_restart();
        test_start_held();
        test_random_programs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mano_control_unit.md
# mano_control_unit

Sequencer and register file for the 8-bit basic computer. It fetches instructions from the 16x8 `MEMORY` block, decodes them, resolves indirect addresses and executes them. It drives `MEMORY`'s `read`/`AR`/`write`/`INDATA` and samples its `OUTDATA`. It also owns PC, AR, IR, DR, AC and E.

## Interface
- No parameters. Address width is fixed at 4 and data width at 8.
- `CLK` input 1: single clock; all state changes on its rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `START` input 1: run request, sampled only in IDLE and HALT.
- `mem_read` output 1: connects to `MEMORY.read`. Combinational from state.
- `mem_write` output 1: connects to `MEMORY.write`. Constant 0 (reserved for a future store instruction).
- `mem_addr` output 4: connects to `MEMORY.AR`. Always equals AR.
- `mem_wdata` output 8: connects to `MEMORY.INDATA`. Always equals AC (reserved).
- `mem_rdata` input 8: connects to `MEMORY.OUTDATA`. Valid in the same cycle `mem_read`=1.
- `AC_OUT` output 8: accumulator.
- `E_OUT` output 1: carry flag.
- `PC_OUT` output 4: program counter.
- `IR_OUT` output 8: instruction register.
- `BUSY` output 1: 1 in every state except IDLE and HALT.
- `HALTED` output 1: 1 only in HALT.

## Operation
- Instruction word format: bit 7 = I (indirect); bits [6:4] = opcode; bits [3:0] = address.
- Opcodes: 000 AND, 001 ADD, 010 LDA, 100 BUN, 111 register-reference (when I=0).
- Register-reference bits: bit3 CLA, bit2 CMA, bit1 INC, bit0 HLT.
  - Multiple bits apply in the order CLA, CMA, INC within one cycle. Example: 0x7E gives AC=0x00.
  - HLT also completes any other set bits.
- Opcodes 011, 101 and 110, and opcode 111 with I=1, are NOPs.
- States and transitions:
  - IDLE: on START=1, go to FETCH_AR.
  - FETCH_AR: AR<=PC. Go to FETCH_IR.
  - FETCH_IR: mem_read=1. IR<=mem_rdata. PC<=PC+1 mod 16. Go to DECODE.
  - DECODE: AR<=IR[3:0].
    - Register-reference: execute. Go to HALT if HLT is set, else FETCH_AR.
    - NOP: go to FETCH_AR.
    - AND/ADD/LDA/BUN with I=1: go to INDIRECT.
    - BUN with I=0: go to EXECUTE.
    - Other memory-reference with I=0: go to OPERAND.
  - INDIRECT: mem_read=1. AR<=mem_rdata[3:0]; bits [7:4] are discarded. Go to EXECUTE for BUN, else OPERAND.
  - OPERAND: mem_read=1. DR<=mem_rdata. Go to EXECUTE.
  - EXECUTE: then go to FETCH_AR.
    - AND: AC<=AC&DR.
    - ADD: {E,AC}<=AC+DR, 9-bit result.
    - LDA: AC<=DR.
    - BUN: PC<=AR.
  - HALT: on START=1, go to FETCH_AR and resume from the current PC.
- Arithmetic rules:
  - INC: AC<=AC+1 mod 256. E is unchanged.
  - CMA: AC<=~AC.
  - CLA: AC<=0.
  - E changes only on ADD.
- `mem_read` is 1 only in FETCH_IR, INDIRECT and OPERAND.

## Timing
- Reset is immediate (asynchronous):
  - state=IDLE.
  - PC, AR, IR, DR, AC and E are all 0.
  - `mem_read`=0, `BUSY`=0, `HALTED`=0.
- START is sampled at the edge. FETCH_AR begins the next cycle. START while BUSY is ignored.
- Cycles per instruction:
  - Register-reference or NOP: 3.
  - BUN direct: 4; BUN indirect: 5.
  - AND/ADD/LDA direct: 5; indirect: 6.
- Register results are visible on outputs the cycle after the executing edge.
- PC wraps from 0xF to 0x0 with no flag.
- RST mid-instruction (for example during OPERAND) aborts with no partial update. All registers reload their reset values.
- START held high stays ignored while running. It restarts the machine only from HALT or IDLE.

## Test plan
Memory is preloaded with the standard `MEMORY` image: 78 74 72 0A 1B 2C 47 8D 9E AF C4 FF FC 19 09 0B. All cycle counts are measured after the accepting edge of a START pulse.

1. Run 9 cycles -> AC=0x00, E=0, PC=3. CMA wraps AC to 0xFF; INC wraps it back to 0x00.
2. Continue 15 cycles (AND 0A, ADD 1B, LDA 2C) -> AC=0xFC, E=0, PC=6. Then 4 more cycles (BUN 47) -> PC=7.
3. Continue 12 cycles (AND 8D, ADD 9E) -> AC=0x5B, E=1. Continue 6 cycles (LDA AF) -> AC=0xFF, E=1, PC=0xA.
4. Continue 5 cycles (BUN C4 via MEM[4]) -> PC=0xB. Then 6 cycles (NOPs FF, FC) -> PC=0xD, AC=0xFF. Then 5 cycles (ADD 19) -> AC=0xAE, E=1.
5. Assert RST while in OPERAND of instruction 0x1B -> on the same cycle all outputs are 0 and the state is IDLE. No activity occurs without a new START.
6. Use an alternate image with MEM[0]=0x71 and MEM[1]=0x78:
   - START -> after 3 cycles HALTED=1, BUSY=0, PC=1.
   - START again -> CLA executes; PC=2 after 3 cycles.
